// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle multiply engine and an iterative restoring divider.
// Define HILO_MACC_EN to build MADD/MSUB (accumulate into HI/LO); otherwise ops 110/111 are ignored.
module hilo_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef HILO_MACC_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;
`endif
  localparam int CW = $clog2(((WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES) + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] rem_q;
  logic             sgn_q;
  logic             neg_q;
  logic             neg_r;
  logic             dz_q;
`ifdef HILO_MACC_EN
  logic             acc_en_q;
  logic             acc_sub_q;
`endif

  // Handshake: an op is taken on a rising edge where op_valid=1, busy=0 and flush=0.
  // op_valid while busy (or together with flush) is dropped, not held for later.
  logic accept;
  assign busy   = (state != IDLE);
  assign accept = op_valid & ~busy & ~flush;

  // Divide operands are reduced to magnitudes at acceptance; signs are kept for the fixup.
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & src_a[WIDTH-1];
  assign b_neg      = div_signed & src_b[WIDTH-1];
  assign a_mag      = a_neg ? -src_a : src_a;
  assign b_mag      = b_neg ? -src_b : src_b;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_res;
  assign ext_a   = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
  assign ext_b   = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
  assign product = ext_a * ext_b;

`ifdef HILO_MACC_EN
  logic [2*WIDTH-1:0] hilo_cur;
  assign hilo_cur = {hi_o, lo_o};
  assign mul_res  = acc_en_q ? (acc_sub_q ? hilo_cur - product : hilo_cur + product) : product;
`else
  assign mul_res  = product;
`endif

  // One restoring step: opa_q shifts the dividend out and the quotient in.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  assign rem_sh   = {rem_q, opa_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign rem_ge   = (rem_sh >= {1'b0, opb_q});
  assign rem_nx   = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx   = {opa_q[WIDTH-2:0], rem_ge};
  assign q_fix    = neg_q ? -opa_q : opa_q;
  assign r_fix    = neg_r ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_o      <= '0;
      lo_o      <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_q      <= 1'b0;
`ifdef HILO_MACC_EN
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi_o <= src_a;
              OP_MTLO: lo_o <= src_a;
              OP_MULT, OP_MULTU: begin
                state <= MUL;
                opa_q <= src_a;
                opb_q <= src_b;
                sgn_q <= (op == OP_MULT);
                cnt   <= CW'(MUL_STAGES - 1);
`ifdef HILO_MACC_EN
                acc_en_q <= 1'b0;
`endif
              end
`ifdef HILO_MACC_EN
              OP_MADD, OP_MSUB: begin
                state     <= MUL;
                opa_q     <= src_a;
                opb_q     <= src_b;
                sgn_q     <= 1'b1;
                cnt       <= CW'(MUL_STAGES - 1);
                acc_en_q  <= 1'b1;
                acc_sub_q <= (op == OP_MSUB);
              end
`endif
              OP_DIV, OP_DIVU: begin
                state <= DIV;
                opa_q <= a_mag;
                opb_q <= b_mag;
                rem_q <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dz_q  <= (src_b == '0);
                cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state       <= IDLE;
            {hi_o, lo_o} <= mul_res;
            done        <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == CW'(WIDTH)) begin
            // Sign fixup cycle; a zero divisor reports but leaves HI/LO alone.
            state    <= IDLE;
            done     <= 1'b1;
            div_zero <= dz_q;
            if (!dz_q) begin
              hi_o <= r_fix;
              lo_o <= q_fix;
            end
          end else begin
            opa_q <= quo_nx;
            rem_q <= rem_nx;
            cnt   <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed vectors plus random ops against a longint reference model.
// Exercises MADD/MSUB when HILO_MACC_EN is defined, otherwise checks that ops 110/111 are ignored.
module tb_hilo_muldiv;
  localparam int W       = 32;
  localparam int MS      = 2;
  localparam int DIV_LAT = W + 1;
`ifdef HILO_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] model_hl;

  hilo_muldiv #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of an op given the current {HI,LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [63:0] hl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return hl;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return hl;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, hl[31:0]};
      3'd5: return {hl[63:32], a};
      3'd6: return MACC ? hl + 64'(sa * sb) : hl;
      default: return MACC ? hl - 64'(sa * sb) : hl;
    endcase
  endfunction

  // Caller is at a negedge with the engine idle; returns at a negedge with the engine idle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at, input bit intrude, input string tag);
    logic [63:0]  exp_hl;
    logic [W-1:0] e_hi, e_lo;
    bit           is_mt, is_div, taken, flushed;
    int           n;
    is_mt  = (o == 3'd4) || (o == 3'd5);
    is_div = (o == 3'd2) || (o == 3'd3);
    taken  = !((o >= 3'd6) && !MACC);
    exp_hl = ref_result(o, a, b, model_hl);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    if (!taken || is_mt) begin
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      if (taken) model_hl = exp_hl;
      check({tag, "_hi"}, hi_o, model_hl[63:32]);
      check({tag, "_lo"}, lo_o, model_hl[31:0]);
      return;
    end
    exp_q.push_back(exp_hl[63:32]);
    exp_q.push_back(exp_hl[31:0]);
    n = 0;
    flushed = 1'b0;
    while (busy && n < 200) begin
      n++;
      if (n == flush_at) begin flush = 1'b1; flushed = 1'b1; end
      if (intrude && n == 3) begin op_valid = 1'b1; op = 3'd5; src_a = $urandom; end
      @(negedge clk);
      flush = 1'b0; op_valid = 1'b0;
      if (flushed) break;
    end
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    if (flushed) begin
      check({tag, "_flush_busy"}, busy, 0);
      check({tag, "_flush_done"}, done, 0);
      check({tag, "_flush_hi"}, hi_o, model_hl[63:32]);
      check({tag, "_flush_lo"}, lo_o, model_hl[31:0]);
      return;
    end
    check({tag, "_latency"}, n, is_div ? DIV_LAT : MS);
    check({tag, "_done"}, done, 1);
    check({tag, "_divzero"}, div_zero, (is_div && b == 0) ? 1 : 0);
    model_hl = {e_hi, e_lo};
    check({tag, "_hi"}, hi_o, e_hi);
    check({tag, "_lo"}, lo_o, e_lo);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           fa;
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    model_hl = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_divzero", div_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'hFFFFFFFE, 32'h3, 0, 0, "mult");
    check("mult_hi_vec", hi_o, 32'hFFFFFFFF);
    check("mult_lo_vec", lo_o, 32'hFFFFFFFA);
    @(negedge clk);
    check("done_pulse_len", done, 0);
    run_op(3'd1, 32'hFFFFFFFE, 32'h3, 0, 0, "multu");
    check("multu_hi_vec", hi_o, 32'h2);
    run_op(3'd2, 32'hFFFFFFF9, 32'h2, 0, 0, "div_neg");
    check("div_neg_lo_vec", lo_o, 32'hFFFFFFFD);
    check("div_neg_hi_vec", hi_o, 32'hFFFFFFFF);
    run_op(3'd3, 32'h7, 32'h2, 0, 0, "divu");
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, "div_min");
    check("div_min_lo_vec", lo_o, 32'h80000000);
    run_op(3'd4, 32'h1234, 32'h0, 0, 0, "mthi");
    run_op(3'd5, 32'h5678, 32'h0, 0, 0, "mtlo");
    run_op(3'd2, 32'h5, 32'h0, 0, 0, "div_by0");
    check("div_by0_hi_vec", hi_o, 32'h1234);
    run_op(3'd2, $urandom, $urandom, 10, 0, "div_flush10");
    run_op(3'd3, $urandom, 32'h13, 0, 1, "divu_mtlo_busy");
    run_op(3'd0, $urandom, $urandom, MS, 0, "mult_flush_last");
    run_op(3'd2, $urandom, $urandom, DIV_LAT, 0, "div_flush_last");

    op_valid = 1'b1; op = 3'd4; src_a = $urandom; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", busy, 0);
    check("idle_flush_hi", hi_o, model_hl[63:32]);

    run_op(3'd0, $urandom, $urandom, 0, 0, "b2b_1");
    run_op(3'd0, $urandom, $urandom, 0, 0, "b2b_2");

    op_valid = 1'b1; op = 3'd0; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    op_valid = 1'b0;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hl = '0;
    check("mid_rst_hi", hi_o, 0);
    check("mid_rst_lo", lo_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);

    run_op(3'd4, 32'h0, 32'h0, 0, 0, "macc_mthi");
    run_op(3'd5, 32'hFFFFFFFF, 32'h0, 0, 0, "macc_mtlo");
    run_op(3'd6, 32'h1, 32'h1, 0, 0, "madd");
`ifdef HILO_MACC_EN
    check("madd_hi_vec", hi_o, 32'h1);
    check("madd_lo_vec", lo_o, 32'h0);
`else
    check("madd_off_lo_vec", lo_o, 32'hFFFFFFFF);
`endif
    run_op(3'd7, 32'h1, 32'h1, 0, 0, "msub");
`ifdef HILO_MACC_EN
    check("msub_hi_vec", hi_o, 32'h0);
    check("msub_lo_vec", lo_o, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (ro == 3'd2 || ro == 3'd3) ? DIV_LAT : MS) : 0;
      run_op(ro, ra, rb, fa, ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
